fp_adder: RTL and testbench

//  Two-stage pipelined adder for the neuron datapath's custom floating-point format:

---
 rtl/fp_adder.sv | 116 +++++++++++
 tb/tb_fp_adder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder.sv
// Purpose: two-stage adder for the sign/6-bit exponent/12-bit explicit-mantissa neuron format.
// Latency: 2 cycles, one result per cycle; the result is registered.
// Backpressure: none, inputs are sampled on every rising edge and outputs hold between updates.
module fp_adder #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 12
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             SignA,
    input  logic             SignB,
    input  logic [EXP_W-1:0] ExponentA,
    input  logic [EXP_W-1:0] ExponentB,
    input  logic [MAN_W-1:0] MantissaA,
    input  logic [MAN_W-1:0] MantissaB,
    output logic             SignOut,
    output logic [EXP_W-1:0] ExponentOut,
    output logic [MAN_W-1:0] MantissaOut,
    output logic             Cout
);

    typedef struct packed {
        logic             sign_a;
        logic             sign_b;
        logic [EXP_W-1:0] exp_l;
        logic [MAN_W-1:0] man_a;
        logic [MAN_W-1:0] man_b;
    } align_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             cout;
    } result_t;

    align_t           align_d, align_q;
    result_t          res_d, res_q;
    logic             a_larger_exp;
    logic [EXP_W-1:0] exp_diff;
    logic [MAN_W:0]   sum;
    logic             sum_sign;
    logic             cancel;

    // Stage 1: align the smaller-exponent operand; shifts past the mantissa width flush to zero.
    always_comb begin
        align_d        = '0;
        a_larger_exp   = (ExponentA >= ExponentB);
        exp_diff       = a_larger_exp ? (ExponentA - ExponentB) : (ExponentB - ExponentA);
        align_d.sign_a = SignA;
        align_d.sign_b = SignB;
        align_d.exp_l  = a_larger_exp ? ExponentA : ExponentB;
        align_d.man_a  = MantissaA;
        align_d.man_b  = MantissaB;
        if (32'(exp_diff) >= MAN_W) begin
            if (a_larger_exp) align_d.man_b = '0;
            else              align_d.man_a = '0;
        end else begin
            if (a_larger_exp) align_d.man_b = MantissaB >> exp_diff;
            else              align_d.man_a = MantissaA >> exp_diff;
        end
    end

    // Stage 2: signed-magnitude add, one-bit right shift on carry, saturate at the top exponent.
    always_comb begin
        res_d    = '0;
        sum      = '0;
        sum_sign = 1'b0;
        cancel   = 1'b0;
        if (align_q.sign_a == align_q.sign_b) begin
            sum      = {1'b0, align_q.man_a} + {1'b0, align_q.man_b};
            sum_sign = align_q.sign_a;
        end else if (align_q.man_a > align_q.man_b) begin
            sum      = {1'b0, align_q.man_a - align_q.man_b};
            sum_sign = align_q.sign_a;
        end else if (align_q.man_b > align_q.man_a) begin
            sum      = {1'b0, align_q.man_b - align_q.man_a};
            sum_sign = align_q.sign_b;
        end else begin
            cancel = 1'b1;
        end

        if (!cancel) begin
            res_d.sign = sum_sign;
            if (sum[MAN_W]) begin
                res_d.cout = 1'b1;
                if (&align_q.exp_l) begin
                    res_d.exp = align_q.exp_l;
                    res_d.man = '1;
                end else begin
                    res_d.exp = align_q.exp_l + 1'b1;
                    res_d.man = sum[MAN_W:1];
                end
            end else begin
                res_d.exp = align_q.exp_l;
                res_d.man = sum[MAN_W-1:0];
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            align_q <= '0;
            res_q   <= '0;
        end else begin
            align_q <= align_d;
            res_q   <= res_d;
        end
    end

    assign SignOut     = res_q.sign;
    assign ExponentOut = res_q.exp;
    assign MantissaOut = res_q.man;
    assign Cout        = res_q.cout;

endmodule

// File: tb/tb_fp_adder.sv
// Scoreboarded bench for fp_adder: directed cases, back-to-back random vectors and a mid-stream reset.
module tb_fp_adder;

    logic        clk;
    logic        rst_n;
    logic        sign_a, sign_b;
    logic [5:0]  exp_a, exp_b;
    logic [11:0] man_a, man_b;
    logic        sign_o;
    logic [5:0]  exp_o;
    logic [11:0] man_o;
    logic        cout_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        s;
        logic [5:0]  e;
        logic [11:0] m;
        logic        c;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    fp_adder #(.EXP_W(6), .MAN_W(12)) dut (
        .Clock       (clk),
        .ResetN      (rst_n),
        .SignA       (sign_a),
        .SignB       (sign_b),
        .ExponentA   (exp_a),
        .ExponentB   (exp_b),
        .MantissaA   (man_a),
        .MantissaB   (man_b),
        .SignOut     (sign_o),
        .ExponentOut (exp_o),
        .MantissaOut (man_o),
        .Cout        (cout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: operands as signed integers, aligned by integer division, summed directly.
    function automatic exp_t model(input logic sa, input int ea, input int ma,
                                   input logic sb, input int eb, input int mb);
        exp_t r;
        int sh, al_a, al_b, expl, va, vb, total, mag;
        r.s = 1'b0; r.e = '0; r.m = '0; r.c = 1'b0; r.due = 0;
        sh   = (ea > eb) ? ea - eb : eb - ea;
        expl = (ea > eb) ? ea : eb;
        al_a = ma;
        al_b = mb;
        if (ea < eb) al_a = (sh >= 12) ? 0 : ma / (1 << sh);
        if (eb < ea) al_b = (sh >= 12) ? 0 : mb / (1 << sh);
        va    = sa ? -al_a : al_a;
        vb    = sb ? -al_b : al_b;
        total = va + vb;
        if (sa != sb && total == 0) return r;
        r.s = (sa == sb) ? sa : (total < 0);
        mag = (total < 0) ? -total : total;
        if (mag >= 4096) begin
            r.c = 1'b1;
            if (expl == 63) begin
                r.e = 6'd63;
                r.m = 12'hFFF;
            end else begin
                r.e = 6'(expl + 1);
                r.m = 12'(mag / 2);
            end
        end else begin
            r.e = 6'(expl);
            r.m = 12'(mag);
        end
        return r;
    endfunction

    task automatic apply(input logic sa, input logic [5:0] ea, input logic [11:0] ma,
                         input logic sb, input logic [5:0] eb, input logic [11:0] mb);
        sign_a = sa; exp_a = ea; man_a = ma;
        sign_b = sb; exp_b = eb; man_b = mb;
    endtask

    task automatic push(input logic s, input logic [5:0] e, input logic [11:0] m,
                        input logic c, input int due);
        exp_t x;
        x.s = s; x.e = e; x.m = m; x.c = c; x.due = due;
        sb_q.push_back(x);
    endtask

    // Directed vector with the expected result written out by hand.
    task automatic directed(input logic sa, input logic [5:0] ea, input logic [11:0] ma,
                            input logic sb, input logic [5:0] eb, input logic [11:0] mb,
                            input logic rs, input logic [5:0] re, input logic [11:0] rm,
                            input logic rc);
        @(negedge clk);
        apply(sa, ea, ma, sb, eb, mb);
        push(rs, re, rm, rc, cyc + 2);
    endtask

    task automatic random_vec();
        logic        sa, sb;
        logic [5:0]  ea, eb;
        logic [11:0] ma, mb;
        exp_t        x;
        sa = 1'($urandom); sb = 1'($urandom);
        ea = 6'($urandom); ma = 12'($urandom);
        case ($urandom_range(0, 3))
            0:       begin eb = ea; mb = ma; end
            1:       begin eb = ea; mb = 12'($urandom); end
            default: begin eb = 6'($urandom); mb = 12'($urandom); end
        endcase
        apply(sa, ea, ma, sb, eb, mb);
        x = model(sa, int'(ea), int'(ma), sb, int'(eb), int'(mb));
        push(x.s, x.e, x.m, x.c, cyc + 2);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({sign_o, exp_o, man_o, cout_o} !== 20'd0) begin
            errors++;
            $display("FAIL %s: got s=%0b e=%0d m=%h c=%0b, expected all zero",
                     name, sign_o, exp_o, man_o, cout_o);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (mon_e.due < cyc) begin
                errors++;
                $display("FAIL result_missed: due cycle %0d, now %0d", mon_e.due, cyc);
            end else if ({sign_o, exp_o, man_o, cout_o} !== {mon_e.s, mon_e.e, mon_e.m, mon_e.c}) begin
                errors++;
                $display("FAIL result@%0d: got s=%0b e=%0d m=%h c=%0b, expected s=%0b e=%0d m=%h c=%0b",
                         cyc, sign_o, exp_o, man_o, cout_o, mon_e.s, mon_e.e, mon_e.m, mon_e.c);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        apply(1'($urandom), 6'($urandom), 12'($urandom), 1'($urandom), 6'($urandom), 12'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply(1'($urandom), 6'($urandom), 12'($urandom), 1'($urandom), 6'($urandom), 12'($urandom));
            check_zero("reset_hold");
        end

        // Release with the first vector present: one edge of zeros, then its result.
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 6'd4, 12'h04C, 1'b0, 6'd4, 12'h163);
        push(1'b0, 6'd0, 12'h000, 1'b0, cyc + 1);
        push(1'b0, 6'd4, 12'h117, 1'b0, cyc + 2);

        directed(1'b0, 6'd5,  12'h100, 1'b0, 6'd3,  12'h080, 1'b0, 6'd5,  12'h120, 1'b0);
        directed(1'b0, 6'd3,  12'h080, 1'b0, 6'd5,  12'h100, 1'b0, 6'd5,  12'h120, 1'b0);
        directed(1'b0, 6'd4,  12'hFFF, 1'b0, 6'd4,  12'h001, 1'b0, 6'd5,  12'h800, 1'b1);
        directed(1'b0, 6'd63, 12'hFFF, 1'b0, 6'd63, 12'h001, 1'b0, 6'd63, 12'hFFF, 1'b1);
        directed(1'b1, 6'd7,  12'h2A0, 1'b0, 6'd7,  12'h2A0, 1'b0, 6'd0,  12'h000, 1'b0);
        directed(1'b1, 6'd20, 12'h123, 1'b0, 6'd4,  12'hFFF, 1'b1, 6'd20, 12'h123, 1'b0);
        directed(1'b1, 6'd9,  12'h001, 1'b1, 6'd9,  12'h002, 1'b1, 6'd9,  12'h003, 1'b0);
        directed(1'b0, 6'd10, 12'h100, 1'b1, 6'd2,  12'hFFF, 1'b0, 6'd10, 12'h0F1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            random_vec();
        end

        // Asynchronous reset between edges must clear the outputs without waiting for a clock.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_now");
        sb_q.delete();
        @(negedge clk);
        check_zero("async_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 6'd0, 12'h000, 1'b0, cyc + 1);
        random_vec();

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            random_vec();
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
